// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory and registers
// the returned word for decode, with stall, redirect/flush, halt and misalignment fault.
module imem_fetch_ctrl #(
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned INS_W       = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_target,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic [INS_W-1:0]       inst,
    output logic [INS_ADDRESS-1:0] inst_pc,
    output logic                   inst_valid,
    output logic                   fault,
    output logic [CNT_W-1:0]       fetch_count
);

    typedef enum logic [1:0] {
        StResetWait = 2'd0,
        StRun       = 2'd1,
        StHalt      = 2'd2,
        StFault     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [INS_ADDRESS-1:0] pc_q, pc_d;
    logic [INS_W-1:0]       inst_q, inst_d;
    logic [INS_ADDRESS-1:0] inst_pc_q, inst_pc_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tgt_aligned;

    assign tgt_aligned = (redirect_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StResetWait;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StResetWait: begin
                inst_valid_d = 1'b0;
                state_d      = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    // Redirect beats stall: the flush must not be lost behind a held pipe.
                    inst_valid_d = 1'b0;
                    if (tgt_aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end else if (halt_req) begin
                    inst_valid_d = 1'b0;
                    state_d      = StHalt;
                end else if (!stall) begin
                    inst_d       = imem_rd;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + INS_ADDRESS'(4);
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHalt: begin
                inst_valid_d = 1'b0;
                // A redirect while halted only retargets (or faults); halt is kept.
                if (redirect_valid) begin
                    if (tgt_aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (resume) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    assign imem_ra     = pc_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, checked every
// cycle against a behavioural fetch model.
module tb_imem_fetch_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int CW = 16;

    localparam int MWait  = 0;
    localparam int MRun   = 1;
    localparam int MHalt  = 2;
    localparam int MFault = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] imem_ra;
    logic [DW-1:0] imem_rd;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          halt_req = 1'b0;
    logic          resume = 1'b0;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          fault;
    logic [CW-1:0] fetch_count;

    logic [DW-1:0] mem [128];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_mode;
    int          m_pc;
    logic [31:0] m_inst;
    int          m_ipc;
    bit          m_valid;
    bit          m_fault;
    int          m_cnt;

    imem_fetch_ctrl #(
        .INS_ADDRESS(AW),
        .INS_W      (DW),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_ra        (imem_ra),
        .imem_rd        (imem_rd),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_ra[AW-1:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit st, input bit rv, input int tgt,
                              input bit hr, input bit rs);
        if (r) begin
            m_mode = MWait; m_pc = 0; m_inst = '0; m_ipc = 0;
            m_valid = 0; m_fault = 0; m_cnt = 0;
        end else if (m_mode == MWait) begin
            m_mode = MRun;
        end else if (m_mode == MRun) begin
            if (rv) begin
                m_valid = 0;
                if (tgt % 4 == 0) m_pc = tgt;
                else begin m_fault = 1; m_mode = MFault; end
            end else if (hr) begin
                m_valid = 0;
                m_mode  = MHalt;
            end else if (!st) begin
                m_inst  = mem[m_pc / 4];
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = (m_pc + 4) % 512;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
        end else if (m_mode == MHalt) begin
            if (rv) begin
                if (tgt % 4 == 0) m_pc = tgt;
                else m_fault = 1;
            end else if (rs) begin
                m_mode = MRun;
            end
        end
    endtask

    task automatic step(input bit r, input bit st, input bit rv, input int tgt,
                        input bit hr, input bit rs);
        reset           = r;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = AW'(tgt);
        halt_req        = hr;
        resume          = rs;
        @(posedge clk);
        model_edge(r, st, rv, tgt, hr, rs);
        #1;
        chk("imem_ra", 32'(imem_ra), 32'(m_pc));
        chk("inst", inst, m_inst);
        chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;

        // Reset and free run
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        run(5);
        chk("first_delivery_cnt", 32'(fetch_count), 32'd4);

        // Stall with delivered inst held
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        run(2);

        // Redirect concurrent with stall while fetching 0x020
        guard = 0;
        while (m_pc != 'h20 && guard < 200) begin run(1); guard++; end
        chk("reach_0x020", 32'(imem_ra), 32'h20);
        step(0, 1, 1, 'h0B4, 0, 0);
        chk("redir_ra", 32'(imem_ra), 32'h0B4);
        run(1);
        chk("redir_ipc", 32'(inst_pc), 32'h0B4);
        run(2);

        // Misaligned redirect faults until reset
        step(0, 0, 1, 'h006, 0, 0);
        run(3);
        step(0, 0, 0, 0, 0, 1);
        chk("fault_sticky", 32'(fault), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("fault_cleared", 32'(fault), 32'd0);

        // Halt at 0x010, resume, halt+resume together
        guard = 0;
        while (m_pc != 'h10 && guard < 200) begin run(1); guard++; end
        step(0, 0, 0, 0, 1, 0);
        run(4);
        chk("halt_ra", 32'(imem_ra), 32'h10);
        step(0, 0, 0, 0, 0, 1);
        run(1);
        chk("resume_ipc", 32'(inst_pc), 32'h10);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        run(3);

        // Wrap at top of memory
        step(0, 0, 1, 'h1FC, 0, 0);
        run(1);
        chk("wrap_ipc", 32'(inst_pc), 32'h1FC);
        chk("wrap_ra", 32'(imem_ra), 32'h0);
        run(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, st, rv, hr, rs;
            int tgt;
            r   = ($urandom_range(99) < 2);
            st  = ($urandom_range(99) < 25);
            rv  = ($urandom_range(99) < 10);
            hr  = ($urandom_range(99) < 6);
            rs  = ($urandom_range(99) < 30);
            tgt = ($urandom_range(99) < 10) ? $urandom_range(511)
                                            : 4 * $urandom_range(127);
            step(r, st, rv, tgt, hr, rs);
        end

        // Counter saturation
        step(1, 0, 0, 0, 0, 0);
        run(65536 + 4);
        chk("cnt_saturated", 32'(fetch_count), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
